// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - valid/ready memory bus with master and slave views
interface mem_bus_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter with slave watchdog
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                   clk,
    input  logic                   resetn,
    mem_bus_arbiter_if.slave       m0,
    mem_bus_arbiter_if.slave       m1,
    mem_bus_arbiter_if.master      s,
    input  logic                   err_clr,
    output logic                   timeout_err,
    output logic                   err_master
);

    localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;
    localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic                grant;
    logic                last;
    logic [WDOG_W-1:0]   wdog;

    logic                busy;
    logic                done_ok;
    logic                expire;
    logic                done;
    logic                pick;
    logic [31:0]         done_rdata;

    always_comb begin
        busy    = (state == BUSY);
        done_ok = busy && s.ready;
        // A slave answering in the expiry cycle still completes normally.
        expire  = busy && !s.ready && (TIMEOUT != 0) && (wdog == WDOG_LAST);
        done    = done_ok || expire;
        done_rdata = done_ok ? s.rdata : ERR_DATA;
        if (m0.valid && m1.valid)
            pick = FIXED_PRIO ? 1'b0 : ~last;
        else
            pick = ~m0.valid;
    end

    always_comb begin
        s.valid = busy;
        s.addr  = '0;
        s.wdata = '0;
        s.wstrb = '0;
        if (busy) begin
            s.addr  = grant ? m1.addr  : m0.addr;
            s.wdata = grant ? m1.wdata : m0.wdata;
            s.wstrb = grant ? m1.wstrb : m0.wstrb;
        end
        m0.ready = done && !grant;
        m1.ready = done && grant;
        m0.rdata = (done && !grant) ? done_rdata : '0;
        m1.rdata = (done && grant)  ? done_rdata : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last        <= 1'b1;
            wdog        <= '0;
            timeout_err <= 1'b0;
            err_master  <= 1'b0;
        end else begin
            if (err_clr)
                timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (m0.valid || m1.valid) begin
                        grant <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done_ok) begin
                        last  <= grant;
                        wdog  <= '0;
                        state <= IDLE;
                    end else if (expire) begin
                        // Ordered after err_clr so a fresh timeout takes precedence.
                        timeout_err <= 1'b1;
                        err_master  <= grant;
                        last        <= grant;
                        wdog        <= '0;
                        state       <= IDLE;
                    end else if (wdog != WDOG_MAX) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        err_clr;
    logic        m0_valid, m1_valid, s_ready;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        terr_rr, emst_rr, terr_fp, emst_fp;
    int          errors = 0;
    int          checks = 0;
    int          cnt0, cnt1;

    always #5 clk = ~clk;

    mem_bus_arbiter_if m0_rr();
    mem_bus_arbiter_if m1_rr();
    mem_bus_arbiter_if s_rr();
    mem_bus_arbiter_if m0_fp();
    mem_bus_arbiter_if m1_fp();
    mem_bus_arbiter_if s_fp();

    assign m0_rr.valid = m0_valid;  assign m0_fp.valid = m0_valid;
    assign m0_rr.addr  = m0_addr;   assign m0_fp.addr  = m0_addr;
    assign m0_rr.wdata = m0_wdata;  assign m0_fp.wdata = m0_wdata;
    assign m0_rr.wstrb = m0_wstrb;  assign m0_fp.wstrb = m0_wstrb;
    assign m1_rr.valid = m1_valid;  assign m1_fp.valid = m1_valid;
    assign m1_rr.addr  = m1_addr;   assign m1_fp.addr  = m1_addr;
    assign m1_rr.wdata = m1_wdata;  assign m1_fp.wdata = m1_wdata;
    assign m1_rr.wstrb = m1_wstrb;  assign m1_fp.wstrb = m1_wstrb;
    assign s_rr.ready  = s_ready;   assign s_fp.ready  = s_ready;
    assign s_rr.rdata  = s_rdata;   assign s_fp.rdata  = s_rdata;

    mem_bus_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .resetn(resetn), .m0(m0_rr.slave), .m1(m1_rr.slave), .s(s_rr.master),
        .err_clr(err_clr), .timeout_err(terr_rr), .err_master(emst_rr)
    );

    mem_bus_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .resetn(resetn), .m0(m0_fp.slave), .m1(m1_fp.slave), .s(s_fp.master),
        .err_clr(err_clr), .timeout_err(terr_fp), .err_master(emst_fp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; err_clr = 1'b0; s_ready = 1'b0; s_rdata = '0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;

        // Reset state
        #12;
        chk("rst_s_valid", s_rr.valid, 0);
        chk("rst_s_addr", s_rr.addr, 0);
        chk("rst_m0_ready", m0_rr.ready, 0);
        chk("rst_m1_ready", m1_rr.ready, 0);
        chk("rst_m0_rdata", m0_rr.rdata, 0);
        chk("rst_timeout_err", terr_rr, 0);
        chk("rst_err_master", emst_rr, 0);
        next_cycle;
        resetn = 1'b1;

        // Single read by m0
        m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'b0000;
        settle;
        chk("rd_idle_s_valid", s_rr.valid, 0);
        next_cycle; settle;
        chk("rd_s_valid", s_rr.valid, 1);
        chk("rd_s_addr", s_rr.addr, 32'h0000_0100);
        chk("rd_m0_ready_early", m0_rr.ready, 0);
        next_cycle;
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        settle;
        chk("rd_m0_ready", m0_rr.ready, 1);
        chk("rd_m0_rdata", m0_rr.rdata, 32'h1234_5678);
        chk("rd_m1_ready", m1_rr.ready, 0);
        chk("rd_m1_rdata", m1_rr.rdata, 0);
        next_cycle;
        m0_valid = 1'b0; s_ready = 1'b0;
        settle;
        chk("rd_after_m0_ready", m0_rr.ready, 0);
        chk("rd_after_s_valid", s_rr.valid, 0);

        // Write passthrough by m1
        m1_valid = 1'b1; m1_addr = 32'h0200_0010; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
        next_cycle; settle;
        chk("wr_s_addr", s_rr.addr, 32'h0200_0010);
        chk("wr_s_wdata_c1", s_rr.wdata, 32'hA5A5_A5A5);
        chk("wr_s_wstrb_c1", s_rr.wstrb, 4'b0011);
        chk("wr_m1_ready_early", m1_rr.ready, 0);
        next_cycle;
        s_ready = 1'b1; s_rdata = 32'h0;
        settle;
        chk("wr_s_wdata_c2", s_rr.wdata, 32'hA5A5_A5A5);
        chk("wr_s_wstrb_c2", s_rr.wstrb, 4'b0011);
        chk("wr_m1_ready", m1_rr.ready, 1);
        chk("wr_m0_ready", m0_rr.ready, 0);
        next_cycle;
        m1_valid = 1'b0; s_ready = 1'b0; m1_wstrb = 4'b0000;
        settle;

        // Contention: round-robin on dut_rr, fixed priority on dut_fp
        m0_valid = 1'b1; m0_addr = 32'h0000_1000;
        m1_valid = 1'b1; m1_addr = 32'h0000_2000;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle; settle;
            chk("rr_grant_addr", s_rr.addr, (i % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000);
            chk("fp_grant_addr", s_fp.addr, 32'h0000_1000);
            next_cycle;
            s_ready = 1'b1; s_rdata = 32'h100 + i;
            settle;
            chk("rr_m0_ready", m0_rr.ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_m1_ready", m1_rr.ready, (i % 2 == 1) ? 1 : 0);
            chk("fp_m1_ready", m1_fp.ready, 0);
            cnt0 += int'(m0_rr.ready);
            cnt1 += int'(m1_rr.ready);
            next_cycle;
            s_ready = 1'b0;
            settle;
        end
        chk("rr_m0_pulses", cnt0, 3);
        chk("rr_m1_pulses", cnt1, 3);
        m0_valid = 1'b0; m1_valid = 1'b0;

        // Timeout on an m1 read
        m1_addr = 32'h0000_3000;
        m1_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            next_cycle; settle;
            if (k < 8) begin
                chk("to_m1_ready_wait", m1_rr.ready, 0);
            end else begin
                chk("to_m1_ready", m1_rr.ready, 1);
                chk("to_m1_rdata", m1_rr.rdata, 32'hDEAD_BEEF);
                chk("to_m0_ready", m0_rr.ready, 0);
            end
        end
        next_cycle;
        m1_valid = 1'b0;
        settle;
        chk("to_timeout_err", terr_rr, 1);
        chk("to_err_master", emst_rr, 1);
        chk("to_fp_timeout_err", terr_fp, 1);
        chk("to_s_valid_idle", s_rr.valid, 0);

        // m0 still served after the timeout
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        next_cycle; settle;
        next_cycle;
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        settle;
        chk("post_to_m0_ready", m0_rr.ready, 1);
        chk("post_to_m0_rdata", m0_rr.rdata, 32'hCAFE_F00D);
        next_cycle;
        m0_valid = 1'b0; s_ready = 1'b0;
        settle;
        chk("post_to_err_sticky", terr_rr, 1);

        err_clr = 1'b1;
        next_cycle;
        err_clr = 1'b0;
        settle;
        chk("err_clr", terr_rr, 0);

        // s_ready in the exact expiry cycle
        m0_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            next_cycle;
            if (k == 8) begin
                s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
            end
            settle;
            if (k == 8) begin
                chk("edge_m0_ready", m0_rr.ready, 1);
                chk("edge_m0_rdata", m0_rr.rdata, 32'h0BAD_F00D);
            end
        end
        next_cycle;
        m0_valid = 1'b0; s_ready = 1'b0;
        settle;
        chk("edge_no_err", terr_rr, 0);

        // err_clr coinciding with a new timeout
        m0_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            next_cycle;
            if (k == 8) err_clr = 1'b1;
            settle;
            if (k == 8) begin
                chk("clr_to_m0_ready", m0_rr.ready, 1);
                chk("clr_to_m0_rdata", m0_rr.rdata, 32'hDEAD_BEEF);
            end
        end
        next_cycle;
        err_clr = 1'b0; m0_valid = 1'b0;
        settle;
        chk("clr_to_set_wins", terr_rr, 1);
        chk("clr_to_err_master", emst_rr, 0);

        // Reset mid-transaction
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        next_cycle; settle;
        chk("mid_s_valid", s_rr.valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_async_s_valid", s_rr.valid, 0);
        chk("mid_async_m0_ready", m0_rr.ready, 0);
        next_cycle; settle;
        chk("mid_hold_m0_ready", m0_rr.ready, 0);
        next_cycle;
        resetn = 1'b1;
        m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
        m0_valid = 1'b1; m1_valid = 1'b1;
        settle;
        chk("post_rst_idle_err", terr_rr, 0);
        next_cycle; settle;
        chk("post_rst_tie_m0", s_rr.addr, 32'h0000_1000);
        next_cycle;
        s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        settle;
        chk("post_rst_m0_ready", m0_rr.ready, 1);
        chk("post_rst_m1_ready", m1_rr.ready, 0);
        next_cycle;
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        settle;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master round-robin arbiter that shares one valid/ready memory-bus slave port (SRAM or iomem window) between the CPU (m0) and a second bus master such as a DMA or data-processor engine (m1).
- Registered grant; the grant is held for the whole transaction.
- A watchdog converts a hung slave into an error completion, so neither master can deadlock the bus.

Parameters:
- TIMEOUT, 255, slave cycles allowed per transaction before forced error completion; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction.
- FIXED_PRIO, 0, 1 means m0 always wins a tie; 0 means round-robin.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  master 0 request; held high until m0_ready
- m0_ready  out  1  master 0 completion pulse
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0 means read
- m0_rdata  out  32  master 0 read data, valid with m0_ready
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0, for master 1
- s_valid  out  1  slave request
- s_ready  in  1  slave completion
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wstrb  out  4  slave byte strobes
- s_rdata  in  32  slave read data
- err_clr  in  1  clears timeout_err
- timeout_err  out  1  sticky: a transaction timed out
- err_master  out  1  master that owned the last timed-out transaction

Behaviour:
- Reset (asynchronous, effective immediately): state=IDLE, grant=0, last=1 (so m0 wins the first tie), wdog=0, timeout_err=0, err_master=0. All m*_ready=0, s_valid=0, s_addr/s_wdata/s_wstrb=0, m*_rdata=0.
- Reset asserted mid-transaction: the transaction is abandoned, s_valid drops in the same cycle, and no ready is issued to either master.
- FSM states are IDLE and BUSY.
- IDLE:
  - No valid input → stay in IDLE.
  - Exactly one valid input → grant that master, go to BUSY.
  - Both valid → with FIXED_PRIO=1, grant m0; otherwise grant !last. Go to BUSY.
  - Grant is registered, so s_valid first rises the cycle after the request is seen.
- BUSY:
  - s_valid=1. s_addr, s_wdata and s_wstrb are combinationally muxed from the granted master.
  - s_ready=1 → granted m*_ready=1 for exactly 1 cycle, with m*_rdata=s_rdata that same cycle. Then last=grant, wdog=0, go to IDLE.
  - s_ready=0 → wdog increments.
  - TIMEOUT≠0 and wdog==TIMEOUT-1 with s_ready=0 → forced completion: granted m*_ready=1 with m*_rdata=ERR_DATA. Also set timeout_err=1, err_master=grant, last=grant, go to IDLE.
  - s_ready and timeout expiry in the same cycle → s_ready wins, no error is recorded.
- Minimum transaction time: 2 cycles (1 arbitration + ≥1 slave). A back-to-back request from the same master re-arbitrates in IDLE.
- The non-granted master always sees m*_ready=0 and m*_rdata=0, and its request stays pending.
- Masters must hold their request signals stable from valid until ready. The arbiter does not latch address or data.
- m*_valid dropping while granted (protocol violation): the transaction still completes on s_ready and the ready pulse is still issued. No recovery beyond that.
- err_clr=1 clears timeout_err next cycle. If a new timeout occurs in the same cycle as err_clr, set wins.
- wdog is $clog2(TIMEOUT+1) bits wide, saturates, and never wraps.
- Fairness: under continuous requests from both masters with FIXED_PRIO=0, grants alternate strictly m0,m1,m0,…

Test Plan:
- Single read: m0_valid, addr=0x0000_0100, wstrb=0; slave answers s_ready one cycle after s_valid with s_rdata=0x1234_5678 → s_addr=0x100 on cycle 1; m0_ready pulses once with m0_rdata=0x1234_5678 on cycle 2; m1_ready stays 0.
- Contention round-robin: m0 and m1 both request continuously for 6 transactions, slave ready after 1 cycle → grant order m0,m1,m0,m1,m0,m1, each master gets exactly 3 ready pulses. Repeat with FIXED_PRIO=1 → m1 receives no grants while m0 stays valid.
- Write passthrough: m1 writes wdata=0xA5A5_A5A5, wstrb=4'b0011 to 0x0200_0010 while m0 is idle → s_wdata=0xA5A5_A5A5 and s_wstrb=4'b0011 for every BUSY cycle; m1_ready pulses on s_ready.
- Timeout with TIMEOUT=8: m1 reads, slave never asserts ready → m1_ready pulses 8 cycles after s_valid rose with m1_rdata=0xDEAD_BEEF; then timeout_err=1, err_master=1. A subsequent m0 request is still served normally.
- Boundary cases:
  - s_ready in the exact expiry cycle → normal data returned, timeout_err stays 0.
  - err_clr together with a new timeout → timeout_err remains 1.
- Reset mid-transaction: assert resetn=0 while BUSY for m0 → s_valid falls asynchronously and no m0_ready is issued. After release, the first tie is granted to m0.
